// File: rtl/spmv_row_mac_pkg.sv
// spmv_row_mac_pkg: shared widths and saturation bounds for the SpMV row MAC.
package spmv_row_mac_pkg;
  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 64;
  localparam int PROD_W     = 2 * DATA_W_DEF;
  localparam int TREE_W     = PROD_W + $clog2(LANES_DEF);
  localparam int CONST_W    = 256;

  function automatic logic signed [CONST_W-1:0] sat_max(input int acc_w);
    return (CONST_W'(1) <<< (acc_w - 1)) - CONST_W'(1);
  endfunction

  function automatic logic signed [CONST_W-1:0] sat_min(input int acc_w);
    return -(CONST_W'(1) <<< (acc_w - 1));
  endfunction
endpackage

// File: rtl/spmv_row_mac_if.sv
// spmv_row_mac_if: paired-operand AXI-Stream input and row-result AXI-Stream output.
interface spmv_row_mac_if
  import spmv_row_mac_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);
  logic [LANES*DATA_W-1:0] s_axis_a_tdata;
  logic [LANES*DATA_W-1:0] s_axis_b_tdata;
  logic [LANES-1:0]        s_axis_tkeep;
  logic                    s_axis_tlast;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [ACC_W-1:0]        m_axis_tdata;
  logic                    m_axis_tuser;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport slave (
    input  s_axis_a_tdata, s_axis_b_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );
  modport master (
    output s_axis_a_tdata, s_axis_b_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
  );
endinterface

// File: rtl/spmv_row_mac_adder_tree.sv
// spmv_adder_tree: combinational pairwise reduction of LANES signed products.
module spmv_adder_tree #(
  parameter int LANES = 4,
  parameter int IN_W  = 64,
  parameter int OUT_W = 66
) (
  input  logic signed [IN_W-1:0]  in_i [LANES],
  output logic signed [OUT_W-1:0] sum_o
);
  localparam int L = $clog2(LANES);
  logic signed [OUT_W-1:0] lvl [L+1][LANES];
  always_comb begin
    lvl = '{default: '0};
    for (int i = 0; i < LANES; i++) lvl[0][i] = OUT_W'(in_i[i]);
    for (int l = 0; l < L; l++)
      for (int i = 0; i < (LANES >> (l + 1)); i++) lvl[l+1][i] = lvl[l][2*i] + lvl[l][2*i+1];
    sum_o = lvl[L][0];
  end
endmodule

// File: rtl/spmv_row_mac.sv
// spmv_row_mac: 3-stage multi-lane MAC producing one dot product per tlast-closed row.
// Define SPMV_MAC_SAT_EN for saturating accumulation with a sticky per-row overflow flag.
module spmv_row_mac
  import spmv_row_mac_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic           aclk,
  input  logic           aresetn,
  spmv_row_mac_if.slave  axis,
  output logic [31:0]    rows_done
);
  localparam int MUL_W = 2 * DATA_W;
  localparam int RED_W = MUL_W + $clog2(LANES);
  // One guard bit over the wider of tree sum and acc so overflow is always visible.
  localparam int EXT_W = (RED_W > ACC_W ? RED_W : ACC_W) + 1;

  logic                    en, rdy_q;
  logic signed [MUL_W-1:0] prod_d [LANES];
  logic signed [MUL_W-1:0] prod_q [LANES];
  logic                    v1_q, l1_q, v2_q, l2_q, mv_q, user_q, ovf_q, ovf_d;
  logic signed [RED_W-1:0] tree_sum, sum2_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, res_q;
  logic signed [EXT_W-1:0] wide;
  logic [31:0]             rows_q;

  assign en                 = axis.m_axis_tready | ~mv_q;
  assign axis.s_axis_tready = en & rdy_q;
  assign axis.m_axis_tvalid = mv_q;
  assign axis.m_axis_tdata  = res_q;
  assign axis.m_axis_tuser  = user_q;
  assign rows_done          = rows_q;

  always_comb
    for (int i = 0; i < LANES; i++)
      prod_d[i] = axis.s_axis_tkeep[i]
        ? MUL_W'($signed(axis.s_axis_a_tdata[i*DATA_W +: DATA_W])) *
          MUL_W'($signed(axis.s_axis_b_tdata[i*DATA_W +: DATA_W]))
        : '0;

  spmv_adder_tree #(.LANES(LANES), .IN_W(MUL_W), .OUT_W(RED_W)) u_tree (
    .in_i  (prod_q),
    .sum_o (tree_sum)
  );

  assign wide = EXT_W'(acc_q) + EXT_W'(sum2_q);

`ifdef SPMV_MAC_SAT_EN
  localparam logic signed [EXT_W-1:0] SMAX = EXT_W'(sat_max(ACC_W));
  localparam logic signed [EXT_W-1:0] SMIN = EXT_W'(sat_min(ACC_W));
  always_comb begin
    acc_d = wide > SMAX ? ACC_W'(SMAX) : wide < SMIN ? ACC_W'(SMIN) : ACC_W'(wide);
    ovf_d = ovf_q | (wide > SMAX) | (wide < SMIN);
  end
`else
  always_comb begin
    acc_d = ACC_W'(wide);
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rdy_q  <= 1'b0;
      v1_q   <= 1'b0;
      l1_q   <= 1'b0;
      prod_q <= '{default: '0};
      v2_q   <= 1'b0;
      l2_q   <= 1'b0;
      sum2_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      mv_q   <= 1'b0;
      res_q  <= '0;
      user_q <= 1'b0;
      rows_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (en) begin
        v1_q   <= axis.s_axis_tvalid & rdy_q;
        l1_q   <= axis.s_axis_tlast;
        prod_q <= prod_d;
        v2_q   <= v1_q;
        l2_q   <= l1_q;
        sum2_q <= tree_sum;
        mv_q   <= v2_q & l2_q;
        if (v2_q) begin
          acc_q <= l2_q ? '0 : acc_d;
          ovf_q <= l2_q ? 1'b0 : ovf_d;
          if (l2_q) begin
            res_q  <= acc_d;
            user_q <= ovf_d;
          end
        end
      end
      if (mv_q & axis.m_axis_tready) rows_q <= rows_q + 32'd1;
    end
endmodule
